fir_mac_sched: RTL and testbench



---
 rtl/fir_sched_pkg.sv | 24 ++
 rtl/fir_tap_cnt.sv | 51 +++++
 rtl/fir_mac_sched.sv | 169 ++++++++++++++++
 tb/tb_fir_mac_sched.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR MAC slice sequencer.
package fir_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [3:0] ENMUL_IDLE = 4'h0;
    localparam logic [3:0] ENMUL_T1   = 4'h1;
    localparam logic [3:0] ENMUL_T2   = 4'h2;
    localparam logic [3:0] ENMUL_T3   = 4'h3;

    localparam int TAPS_PER_ACC = 3;

    // Mirror the upper half of a symmetric impulse response onto the lower half.
    function automatic int sym_fold(input int i, input int n);
        return (i < n - 1 - i) ? i : n - 1 - i;
    endfunction

endpackage

// File: rtl/fir_tap_cnt.sv
// Nested tap (inner, 0..2) / bank (outer) counter for the MAC sequencer.
module fir_tap_cnt
    import fir_sched_pkg::*;
#(
    parameter int NUM_ACC = 11,
    parameter int GW      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [1:0]    k,
    output logic [GW-1:0] g,
    output logic          last
);

    logic [1:0]    k_q, k_d;
    logic [GW-1:0] g_q, g_d;

    assign last = (k_q == 2'(TAPS_PER_ACC - 1)) && (g_q == GW'(NUM_ACC - 1));
    assign k    = k_q;
    assign g    = g_q;

    // Holds at the final tap; only clear returns it to zero.
    always_comb begin
        k_d = k_q;
        g_d = g_q;
        if (clear) begin
            k_d = '0;
            g_d = '0;
        end else if (step && !last) begin
            if (k_q == 2'(TAPS_PER_ACC - 1)) begin
                k_d = '0;
                g_d = g_q + GW'(1);
            end else begin
                k_d = k_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            g_q <= '0;
        end else begin
            k_q <= k_d;
            g_q <= g_d;
        end
    end

endmodule

// File: rtl/fir_mac_sched.sv
// Sequencer for the 3-tap MAC slice bank of the transposed Kaiser FIR.
// Define FIR_SYM_COEF_EN to fold coefficient addresses for a symmetric ROM.
module fir_mac_sched
    import fir_sched_pkg::*;
#(
    parameter int NUM_ACC = 11,
    parameter int ADDR_W  = 6
) (
    input  logic               iClk_12M,
    input  logic               iRst,
    input  logic               iInValid,
    input  logic               iClrErr,
    output logic               oBusy,
    output logic               oShift,
    output logic               oCoeffRd,
    output logic [ADDR_W-1:0]  oCoeffAddr,
    output logic [3:0]         oEnMul,
    output logic               oEnAdd,
    output logic               oEnAcc,
    output logic [NUM_ACC-1:0] oBankSel,
    output logic               oOutValid,
    output logic               oOverrun
);

    localparam int N  = NUM_ACC * TAPS_PER_ACC;
    localparam int GW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    if ((2 ** ADDR_W) < N) begin : g_addr_chk
        $error("fir_mac_sched: ADDR_W too small for NUM_ACC*3 taps");
    end

    state_e state_q, state_d;

    logic [1:0]    k_cnt;
    logic [GW-1:0] g_cnt;
    logic          last_cnt;
    logic          cnt_clear;
    logic          issue;
    int            lin_idx;

    // Tap/bank of the address currently on the ROM bus.
    logic [1:0]    k_show_q, k_show_d;
    logic [GW-1:0] g_show_q, g_show_d;
    logic          last_show_q, last_show_d;

    logic               busy_q, busy_d;
    logic               shift_q, shift_d;
    logic               rd_q, rd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         en_mul_q, en_mul_d;
    logic               en_add_q, en_add_d;
    logic               en_acc_q, en_acc_d;
    logic [NUM_ACC-1:0] bank_sel_q, bank_sel_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    fir_tap_cnt #(
        .NUM_ACC (NUM_ACC),
        .GW      (GW)
    ) u_tap_cnt (
        .clk   (iClk_12M),
        .rst   (iRst),
        .clear (cnt_clear),
        .step  (issue),
        .k     (k_cnt),
        .g     (g_cnt),
        .last  (last_cnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (iInValid) state_d = S_SHIFT;
            S_SHIFT: state_d = S_RUN;
            S_RUN:   if (last_show_q) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter leads the address register by one cycle.
    always_comb begin
        cnt_clear   = (state_q == S_IDLE);
        issue       = (state_d == S_RUN);
        lin_idx     = int'(g_cnt) * TAPS_PER_ACC + int'(k_cnt);
`ifdef FIR_SYM_COEF_EN
        lin_idx     = sym_fold(lin_idx, N);
`endif
        rd_d        = issue;
        addr_d      = issue ? ADDR_W'(lin_idx) : '0;
        k_show_d    = issue ? k_cnt : '0;
        g_show_d    = issue ? g_cnt : '0;
        last_show_d = issue & last_cnt;
    end

    // Enables trail the address by the ROM read latency.
    always_comb begin
        en_mul_d   = ENMUL_IDLE;
        en_add_d   = 1'b0;
        en_acc_d   = 1'b0;
        bank_sel_d = '0;
        if (rd_q) begin
            unique case (1'b1)
                (k_show_q == 2'd0): en_mul_d = ENMUL_T1;
                (k_show_q == 2'd1): en_mul_d = ENMUL_T2;
                default:            en_mul_d = ENMUL_T3;
            endcase
            en_add_d   = 1'b1;
            en_acc_d   = 1'b1;
            bank_sel_d = NUM_ACC'(1) << g_show_q;
        end
    end

    always_comb begin
        busy_d      = (state_d != S_IDLE);
        shift_d     = (state_d == S_SHIFT);
        out_valid_d = (state_d == S_DONE);
        overrun_d   = overrun_q;
        if (iClrErr) overrun_d = 1'b0;
        if (iInValid && state_q != S_IDLE) overrun_d = 1'b1;
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q     <= S_IDLE;
            k_show_q    <= '0;
            g_show_q    <= '0;
            last_show_q <= 1'b0;
            busy_q      <= 1'b0;
            shift_q     <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            en_mul_q    <= ENMUL_IDLE;
            en_add_q    <= 1'b0;
            en_acc_q    <= 1'b0;
            bank_sel_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_show_q    <= k_show_d;
            g_show_q    <= g_show_d;
            last_show_q <= last_show_d;
            busy_q      <= busy_d;
            shift_q     <= shift_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            en_mul_q    <= en_mul_d;
            en_add_q    <= en_add_d;
            en_acc_q    <= en_acc_d;
            bank_sel_q  <= bank_sel_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign oBusy      = busy_q;
    assign oShift     = shift_q;
    assign oCoeffRd   = rd_q;
    assign oCoeffAddr = addr_q;
    assign oEnMul     = en_mul_q;
    assign oEnAdd     = en_add_q;
    assign oEnAcc     = en_acc_q;
    assign oBankSel   = bank_sel_q;
    assign oOutValid  = out_valid_q;
    assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Randomized self-checking bench for fir_mac_sched with a cycle-offset model and slice-array golden check.
module tb_fir_mac_sched;

    localparam int NUM_ACC = 11;
    localparam int ADDR_W  = 6;
    localparam int N       = NUM_ACC * 3;

    logic               clk = 1'b0;
    logic               iRst = 1'b1;
    logic               iInValid = 1'b0;
    logic               iClrErr = 1'b0;
    logic               oBusy, oShift, oCoeffRd, oEnAdd, oEnAcc, oOutValid, oOverrun;
    logic [ADDR_W-1:0]  oCoeffAddr;
    logic [3:0]         oEnMul;
    logic [NUM_ACC-1:0] oBankSel;

    always #5 clk = ~clk;

    fir_mac_sched #(.NUM_ACC(NUM_ACC), .ADDR_W(ADDR_W)) dut (
        .iClk_12M   (clk),
        .iRst       (iRst),
        .iInValid   (iInValid),
        .iClrErr    (iClrErr),
        .oBusy      (oBusy),
        .oShift     (oShift),
        .oCoeffRd   (oCoeffRd),
        .oCoeffAddr (oCoeffAddr),
        .oEnMul     (oEnMul),
        .oEnAdd     (oEnAdd),
        .oEnAcc     (oEnAcc),
        .oBankSel   (oBankSel),
        .oOutValid  (oOutValid),
        .oOverrun   (oOverrun)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int fold(input int i);
`ifdef FIR_SYM_COEF_EN
        return (i < N - 1 - i) ? i : N - 1 - i;
`else
        return i;
`endif
    endfunction

    // Model: d = cycles since the accepting edge (-1 when idle).
    int d = -1;
    bit ovr = 1'b0;

    task automatic check_outs();
        int j;
        logic [NUM_ACC-1:0] bs;
        bit en;
        j  = d - 2;
        en = (j >= 0) && (j < N);
        bs = '0;
        if (en) bs[j / 3] = 1'b1;
        check("busy",     64'(oBusy),     64'(d >= 0));
        check("shift",    64'(oShift),    64'(d == 0));
        check("coeff_rd", 64'(oCoeffRd), 64'(d >= 1 && d <= N));
        if (d >= 1 && d <= N) check("coeff_addr", 64'(oCoeffAddr), 64'(fold(d - 1)));
        check("en_mul",   64'(oEnMul),    en ? 64'(j % 3 + 1) : 64'd0);
        check("en_add",   64'(oEnAdd),    64'(en));
        check("en_acc",   64'(oEnAcc),    64'(en));
        check("bank_sel", 64'(oBankSel),  64'(bs));
        check("out_valid",64'(oOutValid), 64'(d == N + 2));
        check("overrun",  64'(oOverrun),  64'(ovr));
    endtask

    task automatic cyc(input bit v, input bit c, input bit r);
        iInValid = v;
        iClrErr  = c;
        iRst     = r;
        @(posedge clk);
        if (r) begin
            d   = -1;
            ovr = 1'b0;
        end else begin
            if (c) ovr = 1'b0;
            if (v && d >= 0) ovr = 1'b1;
            if (d < 0) d = v ? 0 : -1;
            else begin
                d++;
                if (d > N + 2) d = -1;
            end
        end
        #1;
        check_outs();
        iInValid = 1'b0;
        iClrErr  = 1'b0;
        iRst     = 1'b0;
    endtask

    // External world: coefficient ROM, delay line and slice accumulators.
    int unsigned rom [2**ADDR_W];
    int unsigned rom_q = 0;
    int unsigned xdl [N];
    int unsigned acc [NUM_ACC];
    int unsigned sample = 0;

    always @(posedge clk) begin
        for (int b = 0; b < NUM_ACC; b++) begin
            if (oBankSel[b] && oEnAcc && oEnMul != 4'd0) begin
                if (oEnMul == 4'd1) acc[b] = xdl[b * 3] * rom_q;
                else acc[b] = acc[b] + xdl[b * 3 + int'(oEnMul) - 1] * rom_q;
            end
        end
        if (oCoeffRd) rom_q = rom[oCoeffAddr];
        if (oShift) begin
            for (int i = N - 1; i > 0; i--) xdl[i] = xdl[i - 1];
            xdl[0] = sample;
        end
    end

    initial begin
        int unsigned ysum;
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = $urandom_range(1, 65535);
        for (int i = 0; i < N; i++) xdl[i] = 0;
        for (int b = 0; b < NUM_ACC; b++) acc[b] = 0;

        cyc(0, 0, 1);
        cyc(0, 0, 1);
        check("rst_addr", 64'(oCoeffAddr), 64'd0);
        repeat (3) cyc(0, 0, 0);

        // Single pulse with an overlapping pulse, a clear, then a clean restart.
        cyc(1, 0, 0);
        for (int t = 1; t <= 80; t++) cyc(t == 10 || t == 37, t == 45, 0);

        // Reset in the middle of a sequence, then a full run.
        cyc(1, 0, 0);
        for (int t = 1; t <= 19; t++) cyc(0, 0, 0);
        cyc(0, 0, 1);
        check("rst_mid_busy", 64'(oBusy), 64'd0);
        repeat (2) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (40) cyc(0, 0, 0);

        // Random traffic, clears and occasional resets.
        for (int t = 0; t < 2000; t++)
            cyc($urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 399) == 0);
        repeat (40) cyc(0, 0, 0);

        // Impulse through the slice array reproduces the coefficient sequence.
        for (int n = 0; n < N; n++) begin
            sample = (n == 0) ? 1 : 0;
            cyc(1, 0, 0);
            repeat (N + 2) cyc(0, 0, 0);
            ysum = 0;
            for (int b = 0; b < NUM_ACC; b++) ysum += acc[b];
            check("impulse_y", 64'(ysum), 64'(rom[fold(n)]));
            cyc(0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
